// File: rtl/bht_update_queue_pkg.sv
// Shared types for the BHT update queue: the resolved-branch / BHT-training record
// and the instantiation depth, matching the frontend's ariane_pkg / riscv definitions.
package bht_update_queue_pkg;

  localparam int unsigned VLEN = 64;
  localparam int unsigned BHT_UPDATE_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             incr_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (incr_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bht_update_queue.sv
// Buffers resolved conditional branches and drains them to the BHT one per cycle,
// holding in debug mode, discarding on flush and counting overflow drops.
module bht_update_queue
  import bht_update_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   debug_mode_i,
  input  bht_update_t            resolve_i,
  output bht_update_t            bht_update_o,
  output logic [$clog2(DEPTH):0] occupancy_o,
  output logic [CNT_WIDTH-1:0]   drop_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            taken;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] rptr_d, rptr_q, wptr_d, wptr_q;
  logic [PtrW:0]   occ_d, occ_q;
  logic            push_req, pop, full, accept, drop;

  assign full     = (occ_q == (PtrW + 1)'(DEPTH));
  assign pop      = (occ_q != '0) && !debug_mode_i && !flush_i;
  assign push_req = resolve_i.valid && !debug_mode_i && !flush_i;
  // A full queue still accepts when the head leaves in the same cycle.
  assign accept   = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    occ_d  = occ_q;
    if (flush_i) begin
      rptr_d = '0;
      wptr_d = '0;
      occ_d  = '0;
    end else begin
      if (accept) wptr_d = wptr_q + PtrW'(1);
      if (pop)    rptr_d = rptr_q + PtrW'(1);
      unique case ({accept, pop})
        2'b10:   occ_d = occ_q + (PtrW + 1)'(1);
        2'b01:   occ_d = occ_q - (PtrW + 1)'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      occ_q  <= occ_d;
      if (accept) begin
        mem_q[wptr_q] <= '{pc: resolve_i.pc, taken: resolve_i.taken};
      end
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_drop_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .incr_i(drop),
    .clr_i (1'b0),
    .cnt_o (drop_cnt_o)
  );

  assign bht_update_o.valid = pop;
  assign bht_update_o.pc    = mem_q[rptr_q].pc;
  assign bht_update_o.taken = mem_q[rptr_q].taken;
  assign occupancy_o        = occ_q;

endmodule

// File: tb/tb_bht_update_queue.sv
// Scoreboard bench for bht_update_queue: directed scenarios plus random traffic
// against a queue-based reference model; also exercises sat_counter saturation.
module tb_bht_update_queue;
  import bht_update_queue_pkg::*;

  localparam int unsigned Depth    = 4;
  localparam int unsigned CntWidth = 16;
  localparam int          MaxDrop  = (1 << CntWidth) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush, dbg;
  bht_update_t            resolve, upd;
  logic [$clog2(Depth):0] occ;
  logic [CntWidth-1:0]    drop;
  logic                   s_incr, s_clr;
  logic [1:0]             s_cnt;

  always #5 clk = ~clk;

  bht_update_queue #(
    .DEPTH    (Depth),
    .CNT_WIDTH(CntWidth)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .debug_mode_i(dbg),
    .resolve_i   (resolve),
    .bht_update_o(upd),
    .occupancy_o (occ),
    .drop_cnt_o  (drop)
  );

  sat_counter #(
    .WIDTH(2)
  ) u_sat (
    .clk_i (clk),
    .rst_ni(rst_n),
    .incr_i(s_incr),
    .clr_i (s_clr),
    .cnt_o (s_cnt)
  );

  typedef struct {
    logic [VLEN-1:0] pc;
    logic            taken;
  } ent_t;

  ent_t sb[$];
  ent_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  bit   exp_valid = 1'b0;
  int   exp_occ = 0;
  int   exp_drop_cur = 0;
  int   drop_model = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model state reflects what the DUT holds this cycle.
  task automatic drive(input bit v, input logic [VLEN-1:0] pc, input bit tk, input bit d,
                       input bit f);
    @(posedge clk);
    #1;
    resolve.valid = v;
    resolve.pc    = pc;
    resolve.taken = tk;
    dbg           = d;
    flush         = f;
    exp_occ       = sb.size();
    exp_valid     = (sb.size() != 0) && !d && !f;
    exp_drop_cur  = drop_model;
    if (f) begin
      sb.delete();
    end else if (v && !d) begin
      if (sb.size() == Depth && !exp_valid) begin
        if (drop_model < MaxDrop) drop_model++;
      end else begin
        sb.push_back('{pc: pc, taken: tk});
      end
    end
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("valid", 64'(upd.valid), 64'(exp_valid));
      check("occupancy", 64'(occ), 64'(exp_occ));
      check("drop_cnt", 64'(drop), 64'(exp_drop_cur));
      if (upd.valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_update: got pc %0h expected no update", upd.pc);
        end else begin
          e = sb.pop_front();
          check("pc", upd.pc, e.pc);
          check("taken", 64'(upd.taken), 64'(e.taken));
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_valid", 64'(upd.valid), 64'd0);
    check("rst_pc", upd.pc, 64'd0);
    check("rst_taken", 64'(upd.taken), 64'd0);
    check("rst_occupancy", 64'(occ), 64'd0);
    check("rst_drop_cnt", 64'(drop), 64'd0);
  endtask

  initial begin
    bit rd;
    int sexp;
    rst_n   = 1'b0;
    flush   = 1'b0;
    dbg     = 1'b0;
    resolve = '0;
    s_incr  = 1'b0;
    s_clr   = 1'b0;
    #12;
    check_reset_outputs();
    check("rst_sat", 64'(s_cnt), 64'd0);
    rst_n = 1'b1;

    // Saturating counter: five increments stop at 3, clear wins over increment.
    sexp = 0;
    @(posedge clk);
    #1;
    s_incr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (sexp < 3) sexp++;
      check("sat_cnt", 64'(s_cnt), 64'(sexp));
    end
    s_clr = 1'b1;
    @(posedge clk);
    #1;
    check("sat_clr", 64'(s_cnt), 64'd0);
    s_incr = 1'b0;
    s_clr  = 1'b0;

    // Single update.
    drive(1'b1, 64'h8000_0010, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Resolutions in debug mode are discarded, not dropped.
    for (int i = 0; i < 6; i++) drive(1'b1, 64'h400 + 64'(4 * i), 1'b1, 1'b1, 1'b0);
    idle(2);

    // Hold in debug, then drain.
    drive(1'b1, 64'h100, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h104, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h108, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Back-to-back burst.
    for (int i = 0; i < 8; i++) drive(1'b1, 64'h1000 + 64'(4 * i), i[0], 1'b0, 1'b0);
    idle(3);

    // Flush with a coincident push.
    drive(1'b1, 64'h300, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h304, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h308, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h200, 1'b1, 1'b0, 1'b1);
    idle(3);

    // Random traffic with debug windows and occasional flushes.
    rd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) rd = !rd;
      drive($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, 1'($urandom()), rd,
            $urandom_range(0, 19) == 0);
    end
    idle(3);

    // Reset while an entry is held in debug.
    drive(1'b1, 64'h500, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 64'h504, 1'b0, 1'b1, 1'b0);
    #3;
    mon_en  = 1'b0;
    resolve = '0;
    dbg     = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    drop_model = 0;
    @(posedge clk);
    #2;
    check_reset_outputs();
    rst_n = 1'b1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
